// File: rtl/ps2_keyboard_decoder_pkg.sv
`default_nettype none
// ============================================================================
// ps2_keyboard_decoder_pkg : scancode set 2 constants, ASCII codes, FSM states
// Revision: 1.0
// ============================================================================
package ps2_keyboard_decoder_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_TAB    = 8'h0D;
    localparam logic [7:0] SC_ESC    = 8'h76;

    localparam logic [7:0] ASC_BS    = 8'h08;
    localparam logic [7:0] ASC_TAB   = 8'h09;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_ESC   = 8'h1B;
    localparam logic [7:0] ASC_SPACE = 8'h20;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_BREAK     = 2'd1;
    localparam logic [1:0] S_EXT       = 2'd2;
    localparam logic [1:0] S_EXT_BREAK = 2'd3;

    typedef struct packed {
        logic       hit;
        logic [7:0] ascii;
    } lut_t;

endpackage : ps2_keyboard_decoder_pkg
`default_nettype wire

// File: rtl/ps2_keyboard_decoder_if.sv
`default_nettype none
// ============================================================================
// ps2_keyboard_decoder_if : PS/2 pins in, decoded key stream and status out
// Revision: 1.0
// ============================================================================
interface ps2_keyboard_decoder_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] ascii_char;
    logic       key_pressed;
    logic       frame_error;
    logic       shift_active;
    logic       caps_lock;

    modport slave (
        input  ps2_clk, ps2_dat,
        output ascii_char, key_pressed, frame_error, shift_active, caps_lock
    );

    modport master (
        output ps2_clk, ps2_dat,
        input  ascii_char, key_pressed, frame_error, shift_active, caps_lock
    );
endinterface : ps2_keyboard_decoder_if
`default_nettype wire

// File: rtl/ps2_rx_frame.sv
`default_nettype none
// ============================================================================
// ps2_rx_frame : PS/2 pin synchroniser and 11-bit frame receiver with timeout
// Revision: 1.0
// ============================================================================
module ps2_rx_frame #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  wire logic       clock,
    input  wire logic       resetn,
    input  wire logic       ps2_clk_i,
    input  wire logic       ps2_dat_i,
    output logic [7:0]      rx_byte_o,
    output logic            byte_valid_o,
    output logic            frame_error_o
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;
    logic [3:0]             bitcnt_q, bitcnt_d;
    logic [9:0]             shift_q, shift_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [7:0]             byte_q, byte_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;

    logic                   w_fall;
    logic                   w_bit;
    logic [10:0]            w_frame;

    // Synchronisers reset to the idle-high bus level so release never fakes an edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign w_fall  = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign w_bit   = dat_sync_q[SYNC_STAGES-1];
    assign w_frame = {w_bit, shift_q};

    // w_frame[0] is start, [8:1] data LSB first, [9] parity, [10] stop on the 11th edge.
    always_comb begin
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        tmo_d    = tmo_q;
        byte_d   = byte_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        if (w_fall) begin
            tmo_d   = '0;
            shift_d = w_frame[10:1];
            if (bitcnt_q == 4'd10) begin
                bitcnt_d = 4'd0;
                if (!w_frame[0] && w_frame[10] && (^w_frame[9:1])) begin
                    valid_d = 1'b1;
                    byte_d  = w_frame[8:1];
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                bitcnt_d = bitcnt_q + 4'd1;
            end
        end else if (bitcnt_q != 4'd0) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                bitcnt_d = 4'd0;
                tmo_d    = '0;
                err_d    = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bitcnt_q <= 4'd0;
            shift_q  <= '0;
            tmo_q    <= '0;
            byte_q   <= 8'h00;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            tmo_q    <= tmo_d;
            byte_q   <= byte_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign rx_byte_o     = byte_q;
    assign byte_valid_o  = valid_q;
    assign frame_error_o = err_q;

endmodule : ps2_rx_frame
`default_nettype wire

// File: rtl/ps2_keyboard_decoder.sv
`default_nettype none
// ============================================================================
// ps2_keyboard_decoder : PS/2 scancode set 2 to ASCII keystroke decoder
// Revision: 1.0
// ============================================================================
module ps2_keyboard_decoder
    import ps2_keyboard_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  wire logic                  clock,
    input  wire logic                  resetn,
    ps2_keyboard_decoder_if.slave      kbd
);

    logic [1:0] rst_sync_q;
    logic       w_rst_n;

    logic [7:0] w_rx_byte;
    logic       w_rx_valid;
    logic       w_rx_err;

    logic [1:0] state_q, state_d;
    logic       lshift_q, lshift_d;
    logic       rshift_q, rshift_d;
    logic       caps_held_q, caps_held_d;
    logic       caps_lock_q, caps_lock_d;
    logic       shift_active_q;
    logic       key_pressed_q;
    logic [7:0] ascii_q;
    logic       w_emit;
    logic [7:0] w_ascii;
    lut_t       w_lut;

    // Assert asynchronously, release two clocks later.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign w_rst_n = rst_sync_q[1];

    ps2_rx_frame #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rx (
        .clock         (clock),
        .resetn        (w_rst_n),
        .ps2_clk_i     (kbd.ps2_clk),
        .ps2_dat_i     (kbd.ps2_dat),
        .rx_byte_o     (w_rx_byte),
        .byte_valid_o  (w_rx_valid),
        .frame_error_o (w_rx_err)
    );

    // Letters come out lowercase from the table and are lifted when shift XOR caps.
    function automatic lut_t lookup(input logic [7:0] code, input logic shift, input logic caps);
        lut_t r;
        r.hit   = 1'b1;
        r.ascii = 8'h00;
        case (code)
            8'h1C: r.ascii = 8'h61;  8'h32: r.ascii = 8'h62;  8'h21: r.ascii = 8'h63;
            8'h23: r.ascii = 8'h64;  8'h24: r.ascii = 8'h65;  8'h2B: r.ascii = 8'h66;
            8'h34: r.ascii = 8'h67;  8'h33: r.ascii = 8'h68;  8'h43: r.ascii = 8'h69;
            8'h3B: r.ascii = 8'h6A;  8'h42: r.ascii = 8'h6B;  8'h4B: r.ascii = 8'h6C;
            8'h3A: r.ascii = 8'h6D;  8'h31: r.ascii = 8'h6E;  8'h44: r.ascii = 8'h6F;
            8'h4D: r.ascii = 8'h70;  8'h15: r.ascii = 8'h71;  8'h2D: r.ascii = 8'h72;
            8'h1B: r.ascii = 8'h73;  8'h2C: r.ascii = 8'h74;  8'h3C: r.ascii = 8'h75;
            8'h2A: r.ascii = 8'h76;  8'h1D: r.ascii = 8'h77;  8'h22: r.ascii = 8'h78;
            8'h35: r.ascii = 8'h79;  8'h1A: r.ascii = 8'h7A;
            8'h16: r.ascii = shift ? 8'h21 : 8'h31;
            8'h1E: r.ascii = shift ? 8'h40 : 8'h32;
            8'h26: r.ascii = shift ? 8'h23 : 8'h33;
            8'h25: r.ascii = shift ? 8'h24 : 8'h34;
            8'h2E: r.ascii = shift ? 8'h25 : 8'h35;
            8'h36: r.ascii = shift ? 8'h5E : 8'h36;
            8'h3D: r.ascii = shift ? 8'h26 : 8'h37;
            8'h3E: r.ascii = shift ? 8'h2A : 8'h38;
            8'h46: r.ascii = shift ? 8'h28 : 8'h39;
            8'h45: r.ascii = shift ? 8'h29 : 8'h30;
            8'h0E: r.ascii = shift ? 8'h7E : 8'h60;
            8'h4E: r.ascii = shift ? 8'h5F : 8'h2D;
            8'h55: r.ascii = shift ? 8'h2B : 8'h3D;
            8'h54: r.ascii = shift ? 8'h7B : 8'h5B;
            8'h5B: r.ascii = shift ? 8'h7D : 8'h5D;
            8'h5D: r.ascii = shift ? 8'h7C : 8'h5C;
            8'h4C: r.ascii = shift ? 8'h3A : 8'h3B;
            8'h52: r.ascii = shift ? 8'h22 : 8'h27;
            8'h41: r.ascii = shift ? 8'h3C : 8'h2C;
            8'h49: r.ascii = shift ? 8'h3E : 8'h2E;
            8'h4A: r.ascii = shift ? 8'h3F : 8'h2F;
            SC_SPACE: r.ascii = ASC_SPACE;
            SC_ENTER: r.ascii = ASC_CR;
            SC_BKSP:  r.ascii = ASC_BS;
            SC_TAB:   r.ascii = ASC_TAB;
            SC_ESC:   r.ascii = ASC_ESC;
            default:  r.hit   = 1'b0;
        endcase
        if ((r.ascii >= 8'h61) && (r.ascii <= 8'h7A) && (shift ^ caps))
            r.ascii = r.ascii - 8'h20;
        return r;
    endfunction

    assign w_lut = lookup(w_rx_byte, shift_active_q, caps_lock_q);

    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // A receive error drops any pending E0/F0 prefix.
    always_comb begin
        state_d = state_q;
        if (w_rx_err) begin
            state_d = S_IDLE;
        end else if (w_rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (w_rx_byte == SC_EXT)        state_d = S_EXT;
                    else if (w_rx_byte == SC_BREAK) state_d = S_BREAK;
                end
                S_EXT:   state_d = (w_rx_byte == SC_BREAK) ? S_EXT_BREAK : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_emit      = 1'b0;
        w_ascii     = 8'h00;
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        caps_held_d = caps_held_q;
        caps_lock_d = caps_lock_q;
        if (w_rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    case (w_rx_byte)
                        SC_EXT, SC_BREAK: ;
                        SC_LSHIFT: lshift_d = 1'b1;
                        SC_RSHIFT: rshift_d = 1'b1;
                        SC_CAPS: begin
                            if (!caps_held_q) begin
                                caps_lock_d = ~caps_lock_q;
                                caps_held_d = 1'b1;
                            end
                        end
                        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
                        default: begin
                            w_emit  = w_lut.hit;
                            w_ascii = w_lut.ascii;
                        end
                    endcase
                end
                S_BREAK: begin
                    case (w_rx_byte)
                        SC_LSHIFT: lshift_d    = 1'b0;
                        SC_RSHIFT: rshift_d    = 1'b0;
                        SC_CAPS:   caps_held_d = 1'b0;
                        default: ;
                    endcase
                end
                S_EXT: begin
                    if (w_rx_byte == SC_ENTER) begin
                        w_emit  = 1'b1;
                        w_ascii = ASC_CR;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            lshift_q       <= 1'b0;
            rshift_q       <= 1'b0;
            caps_held_q    <= 1'b0;
            caps_lock_q    <= 1'b0;
            shift_active_q <= 1'b0;
            key_pressed_q  <= 1'b0;
            ascii_q        <= 8'h00;
        end else begin
            lshift_q       <= lshift_d;
            rshift_q       <= rshift_d;
            caps_held_q    <= caps_held_d;
            caps_lock_q    <= caps_lock_d;
            shift_active_q <= lshift_d | rshift_d;
            key_pressed_q  <= w_emit;
            if (w_emit) ascii_q <= w_ascii;
        end
    end

    assign kbd.ascii_char   = ascii_q;
    assign kbd.key_pressed  = key_pressed_q;
    assign kbd.frame_error  = w_rx_err;
    assign kbd.shift_active = shift_active_q;
    assign kbd.caps_lock    = caps_lock_q;

endmodule : ps2_keyboard_decoder
`default_nettype wire
